// File: rtl/spmv_hbm_vec_responder.sv
// AXI3 256-bit slave standing in for an HBM pseudo-channel, backed by an on-chip vector buffer.
// Define SPMV_VEC_RESP_PERF_EN to add the wr_beat_cnt/rd_beat_cnt/err_cnt performance outputs.
module spmv_hbm_vec_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [32:0] BASE_ADDR = 33'h0
) (
  input  logic         pcie_aclk,
  input  logic         pcie_areset,
  input  logic [32:0]  s_axi_hbm_awaddr,
  input  logic [3:0]   s_axi_hbm_awlen,
  input  logic [2:0]   s_axi_hbm_awsize,
  input  logic [1:0]   s_axi_hbm_awburst,
  input  logic         s_axi_hbm_awvalid,
  output logic         s_axi_hbm_awready,
  input  logic [255:0] s_axi_hbm_wdata,
  input  logic [31:0]  s_axi_hbm_wstrb,
  input  logic         s_axi_hbm_wlast,
  input  logic         s_axi_hbm_wvalid,
  output logic         s_axi_hbm_wready,
  output logic [1:0]   s_axi_hbm_bresp,
  output logic         s_axi_hbm_bvalid,
  input  logic         s_axi_hbm_bready,
  input  logic [32:0]  s_axi_hbm_araddr,
  input  logic [3:0]   s_axi_hbm_arlen,
  input  logic [2:0]   s_axi_hbm_arsize,
  input  logic [1:0]   s_axi_hbm_arburst,
  input  logic         s_axi_hbm_arvalid,
  output logic         s_axi_hbm_arready,
  output logic [255:0] s_axi_hbm_rdata,
  output logic [1:0]   s_axi_hbm_rresp,
  output logic         s_axi_hbm_rlast,
  output logic         s_axi_hbm_rvalid,
  input  logic         s_axi_hbm_rready
`ifdef SPMV_VEC_RESP_PERF_EN
  ,
  output logic [31:0]  wr_beat_cnt,
  output logic [31:0]  rd_beat_cnt,
  output logic [15:0]  err_cnt
`endif
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam logic [29:0] BASE_W = {2'b00, BASE_ADDR[32:5]};
  localparam logic [29:0] END_W  = BASE_W + 30'(DEPTH);

  localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;
  localparam logic [1:0] R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2;

  logic [255:0] mem [DEPTH];

  // Sub-word address bits are ignored; every beat is a full 32-byte word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_hbm_awaddr[4:0], s_axi_hbm_araddr[4:0]};

  logic [1:0]  w_state_q, w_state_d;
  logic [27:0] waddr_q, waddr_d;
  logic [3:0]  wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic        wfixed_q, wfixed_d, wlegal_q, wlegal_d, werr_q, werr_d;
  logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [29:0] w_word;
  logic        w_inwin, mem_we;
  logic [AW-1:0] w_idx;

  logic [1:0]  r_state_q, r_state_d;
  logic [27:0] raddr_q, raddr_d;
  logic [3:0]  rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic        rfixed_q, rfixed_d, rlegal_q, rlegal_d, iss_done_q, iss_done_d;
  logic        arready_q, arready_d;
  logic        rv_q, rv_d, rerr_s_q, rerr_s_d, rlast_s_q, rlast_s_d;
  logic [255:0] ram_q, ram_data;
  logic        sk_v_q, sk_v_d, sk_last_q, sk_last_d;
  logic [1:0]  sk_resp_q, sk_resp_d;
  logic [255:0] sk_data_q, sk_data_d;
  logic        rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [255:0] rdata_q, rdata_d;
  logic [29:0] r_word;
  logic        r_inwin, r_ok, pop, issue;
  logic [1:0]  occ;
  logic [AW-1:0] r_idx;

  always_comb begin
    w_word  = {2'b00, waddr_q} + (wfixed_q ? 30'd0 : {26'd0, wcnt_q});
    w_inwin = (w_word >= BASE_W) && (w_word < END_W);
    w_idx   = AW'(w_word - BASE_W);
    r_word  = {2'b00, raddr_q} + (rfixed_q ? 30'd0 : {26'd0, rcnt_q});
    r_inwin = (r_word >= BASE_W) && (r_word < END_W);
    r_idx   = AW'(r_word - BASE_W);
    r_ok    = rlegal_q && r_inwin;
  end

  always_comb begin
    w_state_d = w_state_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wcnt_d    = wcnt_q;
    wfixed_d  = wfixed_q;
    wlegal_d  = wlegal_q;
    werr_d    = werr_q;
    mem_we    = 1'b0;
    case (w_state_q)
      W_IDLE: if (awready_q && s_axi_hbm_awvalid) begin
        waddr_d   = s_axi_hbm_awaddr[32:5];
        wlen_d    = s_axi_hbm_awlen;
        wcnt_d    = '0;
        wfixed_d  = (s_axi_hbm_awburst == 2'b00);
        wlegal_d  = (s_axi_hbm_awsize == 3'b101) && !s_axi_hbm_awburst[1];
        werr_d    = 1'b0;
        w_state_d = W_DATA;
      end
      W_DATA: if (wready_q && s_axi_hbm_wvalid) begin
        mem_we = wlegal_q && w_inwin;
        if (!wlegal_q || !w_inwin || (s_axi_hbm_wlast != (wcnt_q == wlen_q))) werr_d = 1'b1;
        if (wcnt_q == wlen_q) w_state_d = W_RESP;
        else wcnt_d = wcnt_q + 4'd1;
      end
      W_RESP: if (bvalid_q && s_axi_hbm_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
    bresp_d   = ((w_state_d == W_RESP) && werr_d) ? 2'b10 : 2'b00;
  end

  // Output register plus one skid entry; issue only when the beat in flight from the RAM
  // is guaranteed a slot, which keeps one beat per cycle with rready held high.
  always_comb begin
    pop      = rvalid_q && s_axi_hbm_rready;
    occ      = {1'b0, rvalid_q} + {1'b0, sk_v_q} + {1'b0, rv_q};
    issue    = (r_state_q != R_IDLE) && !iss_done_q && ((occ - {1'b0, pop}) < 2'd2);
    ram_data = rerr_s_q ? '0 : ram_q;

    r_state_d  = r_state_q;
    raddr_d    = raddr_q;
    rlen_d     = rlen_q;
    rcnt_d     = rcnt_q;
    rfixed_d   = rfixed_q;
    rlegal_d   = rlegal_q;
    iss_done_d = iss_done_q;
    case (r_state_q)
      R_IDLE: if (arready_q && s_axi_hbm_arvalid) begin
        raddr_d    = s_axi_hbm_araddr[32:5];
        rlen_d     = s_axi_hbm_arlen;
        rcnt_d     = '0;
        rfixed_d   = (s_axi_hbm_arburst == 2'b00);
        rlegal_d   = (s_axi_hbm_arsize == 3'b101) && !s_axi_hbm_arburst[1];
        iss_done_d = 1'b0;
        r_state_d  = R_FETCH;
      end
      R_FETCH: r_state_d = R_DATA;
      R_DATA:  if (pop && rlast_q) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
    if (issue) begin
      if (rcnt_q == rlen_q) iss_done_d = 1'b1;
      else rcnt_d = rcnt_q + 4'd1;
    end
    rv_d      = issue;
    rerr_s_d  = !r_ok;
    rlast_s_d = (rcnt_q == rlen_q);
    arready_d = (r_state_d == R_IDLE);

    sk_v_d    = sk_v_q;
    sk_data_d = sk_data_q;
    sk_resp_d = sk_resp_q;
    sk_last_d = sk_last_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    if (!rvalid_q || pop) begin
      if (sk_v_q) begin
        rvalid_d = 1'b1;
        rdata_d  = sk_data_q;
        rresp_d  = sk_resp_q;
        rlast_d  = sk_last_q;
        sk_v_d   = rv_q;
      end else if (rv_q) begin
        rvalid_d = 1'b1;
        rdata_d  = ram_data;
        rresp_d  = rerr_s_q ? 2'b10 : 2'b00;
        rlast_d  = rlast_s_q;
      end else begin
        rvalid_d = 1'b0;
        rresp_d  = 2'b00;
        rlast_d  = 1'b0;
      end
    end else if (rv_q) begin
      sk_v_d = 1'b1;
    end
    if (rv_q) begin
      sk_data_d = ram_data;
      sk_resp_d = rerr_s_q ? 2'b10 : 2'b00;
      sk_last_d = rlast_s_q;
    end
  end

  // Buffer is not reset; the read port samples before the write lands (read-first).
  always_ff @(posedge pcie_aclk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 32; i++) begin
        if (s_axi_hbm_wstrb[i]) mem[w_idx][i*8 +: 8] <= s_axi_hbm_wdata[i*8 +: 8];
      end
    end
    if (issue) ram_q <= mem[r_idx];
  end

  always_ff @(posedge pcie_aclk or posedge pcie_areset) begin
    if (pcie_areset) begin
      w_state_q <= W_IDLE;  waddr_q <= '0;  wlen_q <= '0;  wcnt_q <= '0;
      wfixed_q <= 1'b0;  wlegal_q <= 1'b0;  werr_q <= 1'b0;
      awready_q <= 1'b0;  wready_q <= 1'b0;  bvalid_q <= 1'b0;  bresp_q <= '0;
      r_state_q <= R_IDLE;  raddr_q <= '0;  rlen_q <= '0;  rcnt_q <= '0;
      rfixed_q <= 1'b0;  rlegal_q <= 1'b0;  iss_done_q <= 1'b0;  arready_q <= 1'b0;
      rv_q <= 1'b0;  rerr_s_q <= 1'b0;  rlast_s_q <= 1'b0;
      sk_v_q <= 1'b0;  sk_data_q <= '0;  sk_resp_q <= '0;  sk_last_q <= 1'b0;
      rvalid_q <= 1'b0;  rdata_q <= '0;  rresp_q <= '0;  rlast_q <= 1'b0;
    end else begin
      w_state_q <= w_state_d;  waddr_q <= waddr_d;  wlen_q <= wlen_d;  wcnt_q <= wcnt_d;
      wfixed_q <= wfixed_d;  wlegal_q <= wlegal_d;  werr_q <= werr_d;
      awready_q <= awready_d;  wready_q <= wready_d;  bvalid_q <= bvalid_d;  bresp_q <= bresp_d;
      r_state_q <= r_state_d;  raddr_q <= raddr_d;  rlen_q <= rlen_d;  rcnt_q <= rcnt_d;
      rfixed_q <= rfixed_d;  rlegal_q <= rlegal_d;  iss_done_q <= iss_done_d;  arready_q <= arready_d;
      rv_q <= rv_d;  rerr_s_q <= rerr_s_d;  rlast_s_q <= rlast_s_d;
      sk_v_q <= sk_v_d;  sk_data_q <= sk_data_d;  sk_resp_q <= sk_resp_d;  sk_last_q <= sk_last_d;
      rvalid_q <= rvalid_d;  rdata_q <= rdata_d;  rresp_q <= rresp_d;  rlast_q <= rlast_d;
    end
  end

  assign s_axi_hbm_awready = awready_q;
  assign s_axi_hbm_wready  = wready_q;
  assign s_axi_hbm_bvalid  = bvalid_q;
  assign s_axi_hbm_bresp   = bresp_q;
  assign s_axi_hbm_arready = arready_q;
  assign s_axi_hbm_rvalid  = rvalid_q;
  assign s_axi_hbm_rdata   = rdata_q;
  assign s_axi_hbm_rresp   = rresp_q;
  assign s_axi_hbm_rlast   = rlast_q;

`ifdef SPMV_VEC_RESP_PERF_EN
  logic [31:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        racc_q, racc_d;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;

  // A read burst counts as one error if any of its beats carried SLVERR.
  always_comb begin
    racc_d = racc_q;
    if (pop) racc_d = rlast_q ? 1'b0 : (racc_q || (rresp_q == 2'b10));
    err_inc = {1'b0, bvalid_q && s_axi_hbm_bready && (bresp_q == 2'b10)}
            + {1'b0, pop && rlast_q && (racc_q || (rresp_q == 2'b10))};
    err_sum   = {1'b0, err_cnt_q} + {15'd0, err_inc};
    err_cnt_d = err_sum[16] ? '1 : err_sum[15:0];
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    if ((w_state_q == W_DATA) && wready_q && s_axi_hbm_wvalid && (wr_cnt_q != '1))
      wr_cnt_d = wr_cnt_q + 32'd1;
    if (pop && (rd_cnt_q != '1)) rd_cnt_d = rd_cnt_q + 32'd1;
  end

  always_ff @(posedge pcie_aclk or posedge pcie_areset) begin
    if (pcie_areset) begin
      wr_cnt_q <= '0;  rd_cnt_q <= '0;  err_cnt_q <= '0;  racc_q <= 1'b0;
    end else begin
      wr_cnt_q <= wr_cnt_d;  rd_cnt_q <= rd_cnt_d;  err_cnt_q <= err_cnt_d;  racc_q <= racc_d;
    end
  end

  assign wr_beat_cnt = wr_cnt_q;
  assign rd_beat_cnt = rd_cnt_q;
  assign err_cnt     = err_cnt_q;
`endif

endmodule

// File: tb/tb_spmv_hbm_vec_responder.sv
// Randomized self-checking bench for spmv_hbm_vec_responder against a word-array reference model.
`timescale 1ns/1ps
module tb_spmv_hbm_vec_responder;
  localparam int unsigned DEPTH = 64;
  localparam logic [32:0] BASE  = 33'h0_0000_2000;

  logic clk = 1'b0, rst;
  logic [32:0] awaddr, araddr;
  logic [3:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;
  logic [255:0] wdata, rdata;
  logic [31:0] wstrb;
`ifdef SPMV_VEC_RESP_PERF_EN
  logic [31:0] wr_beat_cnt, rd_beat_cnt;
  logic [15:0] err_cnt;
`endif

  always #5 clk = ~clk;

  spmv_hbm_vec_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .pcie_aclk(clk), .pcie_areset(rst),
    .s_axi_hbm_awaddr(awaddr), .s_axi_hbm_awlen(awlen), .s_axi_hbm_awsize(awsize),
    .s_axi_hbm_awburst(awburst), .s_axi_hbm_awvalid(awvalid), .s_axi_hbm_awready(awready),
    .s_axi_hbm_wdata(wdata), .s_axi_hbm_wstrb(wstrb), .s_axi_hbm_wlast(wlast),
    .s_axi_hbm_wvalid(wvalid), .s_axi_hbm_wready(wready),
    .s_axi_hbm_bresp(bresp), .s_axi_hbm_bvalid(bvalid), .s_axi_hbm_bready(bready),
    .s_axi_hbm_araddr(araddr), .s_axi_hbm_arlen(arlen), .s_axi_hbm_arsize(arsize),
    .s_axi_hbm_arburst(arburst), .s_axi_hbm_arvalid(arvalid), .s_axi_hbm_arready(arready),
    .s_axi_hbm_rdata(rdata), .s_axi_hbm_rresp(rresp), .s_axi_hbm_rlast(rlast),
    .s_axi_hbm_rvalid(rvalid), .s_axi_hbm_rready(rready)
`ifdef SPMV_VEC_RESP_PERF_EN
    , .wr_beat_cnt(wr_beat_cnt), .rd_beat_cnt(rd_beat_cnt), .err_cnt(err_cnt)
`endif
  );

  int n_tests = 0, n_fail = 0;
  logic [255:0] model_mem [DEPTH];
  logic [255:0] wd [16];
  logic [31:0]  ws [16];
  logic [255:0] got_d [$];
  logic [1:0]   got_r [$];
  logic         got_l [$];
  int lat, stab_err;

  // ---------------- reference model ----------------
  function automatic bit is_legal(input logic [2:0] sz, input logic [1:0] bu);
    return (sz == 3'b101) && (bu == 2'b00 || bu == 2'b01);
  endfunction

  function automatic int beat_idx(input logic [32:0] a, input int k, input logic [1:0] bu);
    longint off;
    off = longint'(a) - longint'(BASE);
    if (off < 0) return -1;
    off = off / 32 + ((bu == 2'b00) ? 0 : k);
    if (off >= longint'(DEPTH)) return -1;
    return int'(off);
  endfunction

  function automatic logic [1:0] model_write(input logic [32:0] a, input logic [3:0] len,
      input logic [2:0] sz, input logic [1:0] bu, input int wlast_at);
    bit err, lg;
    int idx;
    lg  = is_legal(sz, bu);
    err = !lg || (wlast_at != int'(len));
    for (int k = 0; k <= int'(len); k++) begin
      idx = beat_idx(a, k, bu);
      if (idx < 0) err = 1'b1;
      else if (lg)
        for (int b = 0; b < 32; b++)
          if (ws[k][b]) model_mem[idx][b*8 +: 8] = wd[k][b*8 +: 8];
    end
    return err ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [255:0] exp_rd(input logic [32:0] a, input logic [2:0] sz,
      input logic [1:0] bu, input int k);
    int idx;
    idx = beat_idx(a, k, bu);
    if (!is_legal(sz, bu) || idx < 0) return '0;
    return model_mem[idx];
  endfunction

  function automatic logic [1:0] exp_rr(input logic [32:0] a, input logic [2:0] sz,
      input logic [1:0] bu, input int k);
    return (is_legal(sz, bu) && beat_idx(a, k, bu) >= 0) ? 2'b00 : 2'b10;
  endfunction

  // ---------------- bus drivers ----------------
  task automatic axi_write(input logic [32:0] a, input logic [3:0] len, input logic [2:0] sz,
      input logic [1:0] bu, input int wlast_at, output logic [1:0] br, output bit to);
    int n;
    to = 1'b0;
    @(negedge clk);
    awaddr = a; awlen = len; awsize = sz; awburst = bu; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) to = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      wdata = wd[k]; wstrb = ws[k]; wlast = (k == wlast_at); wvalid = 1'b1;
      n = 0;
      while (!wready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) to = 1'b1;
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    n = 0;
    while (!bvalid && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) to = 1'b1;
    br = bresp;
    @(negedge clk);
    bready = 1'b0;
  endtask

  // mode 0: rready always high, 1: toggles starting high, 2: random
  task automatic axi_read(input logic [32:0] a, input logic [3:0] len, input logic [2:0] sz,
      input logic [1:0] bu, input int mode, output bit to);
    int n;
    bit done, rr, prev_stall;
    logic [255:0] pd;
    logic [1:0] pr;
    logic pl;
    got_d.delete(); got_r.delete(); got_l.delete();
    stab_err = 0; to = 1'b0; prev_stall = 1'b0; done = 1'b0;
    @(negedge clk);
    araddr = a; arlen = len; arsize = sz; arburst = bu; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    while (!arready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) to = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 50) begin @(negedge clk); lat++; end
    n = 0;
    while (!done && n < 400) begin
      rr = (mode == 0) ? 1'b1 : (mode == 1) ? (n % 2 == 0) : 1'($urandom_range(0, 1));
      rready = rr;
      if (prev_stall && (!rvalid || rdata !== pd || rresp !== pr || rlast !== pl)) stab_err++;
      if (rvalid && rr) begin
        got_d.push_back(rdata); got_r.push_back(rresp); got_l.push_back(rlast);
        if (rlast || got_d.size() > 16) done = 1'b1;
      end
      prev_stall = rvalid && !rr;
      pd = rdata; pr = rresp; pl = rlast;
      @(negedge clk);
      n++;
    end
    rready = 1'b0;
    if (!done) to = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    awvalid = 0; wvalid = 0; wlast = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = '0; awlen = '0; awsize = '0; awburst = '0; wdata = '0; wstrb = '0;
    araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({awready, wready, bvalid, bresp, arready, rvalid, rlast, rresp, rdata} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got aw%b w%b bv%b br%b ar%b rv%b rl%b rr%b rd=%h expected all 0",
        awready, wready, bvalid, bresp, arready, rvalid, rlast, rresp, rdata);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({awready, arready} !== 2'b11) begin
      n_fail++; $display("FAIL post_reset_ready: got awready=%b arready=%b expected 1 1", awready, arready);
    end
  endtask

  task automatic test_fill;
    logic [1:0] br, eb;
    bit to;
    for (int b = 0; b < int'(DEPTH) / 16; b++) begin
      for (int k = 0; k < 16; k++) begin wd[k] = {8{$urandom()}}; ws[k] = '1; end
      eb = model_write(BASE + 33'(b * 512), 4'd15, 3'b101, 2'b01, 15);
      axi_write(BASE + 33'(b * 512), 4'd15, 3'b101, 2'b01, 15, br, to);
      n_tests++;
      if (to || br !== eb) begin
        n_fail++; $display("FAIL fill_bresp[%0d]: got %b timeout=%0d expected %b", b, br, to, eb);
      end
    end
  endtask

  task automatic test_basic;
    logic [1:0] br;
    bit to;
    for (int k = 0; k < 4; k++) begin wd[k] = 256'(8'hA0 + k); ws[k] = '1; end
    void'(model_write(BASE + 33'h40, 4'd3, 3'b101, 2'b01, 3));
    axi_write(BASE + 33'h40, 4'd3, 3'b101, 2'b01, 3, br, to);
    n_tests++;
    if (to || br !== 2'b00) begin n_fail++; $display("FAIL basic_bresp: got %b timeout=%0d expected 00", br, to); end
    axi_read(BASE + 33'h40, 4'd3, 3'b101, 2'b01, 0, to);
    n_tests++;
    if (to || lat !== 2) begin n_fail++; $display("FAIL basic_latency: got %0d timeout=%0d expected 2", lat, to); end
    n_tests++;
    if (got_d.size() != 4) begin n_fail++; $display("FAIL basic_count: got %0d expected 4", got_d.size()); end
    for (int k = 0; k < got_d.size() && k < 4; k++) begin
      n_tests++;
      if (got_d[k] !== 256'(8'hA0 + k) || got_r[k] !== 2'b00 || got_l[k] !== (k == 3)) begin
        n_fail++; $display("FAIL basic_beat[%0d]: got d=%h r=%b l=%b expected d=%h r=00 l=%0d",
          k, got_d[k], got_r[k], got_l[k], 256'(8'hA0 + k), (k == 3));
      end
    end
  endtask

  task automatic test_strobe;
    logic [1:0] br;
    bit to;
    wd[0] = '1; ws[0] = '1;
    void'(model_write(BASE + 33'(5 * 32), 4'd0, 3'b101, 2'b01, 0));
    axi_write(BASE + 33'(5 * 32), 4'd0, 3'b101, 2'b01, 0, br, to);
    wd[0] = '0; ws[0] = 32'h0000_000F;
    void'(model_write(BASE + 33'(5 * 32), 4'd0, 3'b101, 2'b01, 0));
    axi_write(BASE + 33'(5 * 32), 4'd0, 3'b101, 2'b01, 0, br, to);
    axi_read(BASE + 33'(5 * 32) + 33'h7, 4'd0, 3'b101, 2'b01, 0, to);
    n_tests++;
    if (to || got_d.size() != 1 || got_d[0] !== {{224{1'b1}}, 32'h0} || got_r[0] !== 2'b00) begin
      n_fail++; $display("FAIL strobe_word5: got %h timeout=%0d expected %h", got_d.size() ? got_d[0] : '0, to, {{224{1'b1}}, 32'h0});
    end
  endtask

  task automatic test_rready_toggle;
    logic [1:0] br;
    bit to;
    for (int k = 0; k < 16; k++) begin wd[k] = {8{$urandom()}}; ws[k] = $urandom(); end
    void'(model_write(BASE + 33'(16 * 32), 4'd15, 3'b101, 2'b01, 15));
    axi_write(BASE + 33'(16 * 32), 4'd15, 3'b101, 2'b01, 15, br, to);
    axi_read(BASE + 33'(16 * 32), 4'd15, 3'b101, 2'b01, 1, to);
    n_tests++;
    if (to || got_d.size() != 16) begin n_fail++; $display("FAIL toggle_count: got %0d timeout=%0d expected 16", got_d.size(), to); end
    n_tests++;
    if (stab_err !== 0) begin n_fail++; $display("FAIL toggle_stall_stable: got %0d changes expected 0", stab_err); end
    for (int k = 0; k < got_d.size() && k < 16; k++) begin
      n_tests++;
      if (got_d[k] !== exp_rd(BASE + 33'(16 * 32), 3'b101, 2'b01, k) || got_l[k] !== (k == 15)) begin
        n_fail++; $display("FAIL toggle_beat[%0d]: got d=%h l=%b expected d=%h l=%0d",
          k, got_d[k], got_l[k], exp_rd(BASE + 33'(16 * 32), 3'b101, 2'b01, k), (k == 15));
      end
    end
  endtask

  task automatic test_boundary;
    logic [1:0] br, eb;
    logic [32:0] a;
    bit to;
    a = BASE + 33'((DEPTH - 2) * 32);
    for (int k = 0; k < 4; k++) begin wd[k] = {8{$urandom()}}; ws[k] = '1; end
    eb = model_write(a, 4'd3, 3'b101, 2'b01, 3);
    axi_write(a, 4'd3, 3'b101, 2'b01, 3, br, to);
    n_tests++;
    if (to || br !== eb || br !== 2'b10) begin n_fail++; $display("FAIL boundary_bresp: got %b expected 10", br); end
    axi_read(a, 4'd3, 3'b101, 2'b01, 0, to);
    n_tests++;
    if (to || got_d.size() != 4) begin n_fail++; $display("FAIL boundary_count: got %0d expected 4", got_d.size()); end
    for (int k = 0; k < got_d.size() && k < 4; k++) begin
      n_tests++;
      if (got_d[k] !== exp_rd(a, 3'b101, 2'b01, k) || got_r[k] !== ((k < 2) ? 2'b00 : 2'b10)) begin
        n_fail++; $display("FAIL boundary_beat[%0d]: got d=%h r=%b expected d=%h r=%b",
          k, got_d[k], got_r[k], exp_rd(a, 3'b101, 2'b01, k), (k < 2) ? 2'b00 : 2'b10);
      end
    end
    axi_read(BASE - 33'd32, 4'd1, 3'b101, 2'b01, 0, to);
    n_tests++;
    if (to || got_d.size() != 2 || got_r[0] !== 2'b10 || got_d[0] !== '0 || got_r[1] !== 2'b00) begin
      n_fail++; $display("FAIL below_base: got n=%0d r0=%b expected n=2 r0=10 r1=00", got_d.size(), got_r.size() ? got_r[0] : 2'b00);
    end
  endtask

  task automatic test_illegal;
    logic [1:0] br;
    bit to;
    for (int k = 0; k < 4; k++) begin wd[k] = {8{$urandom()}}; ws[k] = '1; end
    void'(model_write(BASE + 33'h100, 4'd3, 3'b100, 2'b01, 3));
    axi_write(BASE + 33'h100, 4'd3, 3'b100, 2'b01, 3, br, to);
    n_tests++;
    if (to || br !== 2'b10) begin n_fail++; $display("FAIL illegal_size_bresp: got %b expected 10", br); end
    void'(model_write(BASE + 33'h100, 4'd3, 3'b101, 2'b10, 3));
    axi_write(BASE + 33'h100, 4'd3, 3'b101, 2'b10, 3, br, to);
    n_tests++;
    if (to || br !== 2'b10) begin n_fail++; $display("FAIL illegal_burst_bresp: got %b expected 10", br); end
    axi_read(BASE + 33'h100, 4'd3, 3'b101, 2'b01, 2, to);
    for (int k = 0; k < got_d.size() && k < 4; k++) begin
      n_tests++;
      if (got_d[k] !== exp_rd(BASE + 33'h100, 3'b101, 2'b01, k)) begin
        n_fail++; $display("FAIL illegal_unchanged[%0d]: got %h expected %h", k, got_d[k], exp_rd(BASE + 33'h100, 3'b101, 2'b01, k));
      end
    end
    void'(model_write(BASE + 33'h100, 4'd3, 3'b101, 2'b01, 1));
    axi_write(BASE + 33'h100, 4'd3, 3'b101, 2'b01, 1, br, to);
    n_tests++;
    if (to || br !== 2'b10) begin n_fail++; $display("FAIL wlast_early_bresp: got %b expected 10", br); end
    axi_read(BASE + 33'h100, 4'd1, 3'b100, 2'b01, 0, to);
    n_tests++;
    if (to || got_d.size() != 2 || got_d[0] !== '0 || got_r[0] !== 2'b10 || got_r[1] !== 2'b10 || got_l[1] !== 1'b1) begin
      n_fail++; $display("FAIL illegal_read: got n=%0d r0=%b expected n=2 data 0 resp 10", got_d.size(), got_r.size() ? got_r[0] : 2'b00);
    end
  endtask

  task automatic test_random;
    logic [1:0] br, eb, bu;
    logic [3:0] len;
    logic [32:0] a;
    bit to;
    int wr;
    for (int it = 0; it < 10; it++) begin
      wr  = int'($urandom_range(0, DEPTH + 3)) - 2;
      a   = 33'(longint'(BASE) + longint'(wr) * 32 + longint'($urandom_range(0, 31)));
      len = 4'($urandom_range(0, 15));
      bu  = 2'($urandom_range(0, 1));
      for (int k = 0; k < 16; k++) begin wd[k] = {8{$urandom()}}; ws[k] = $urandom(); end
      eb = model_write(a, len, 3'b101, bu, int'(len));
      axi_write(a, len, 3'b101, bu, int'(len), br, to);
      n_tests++;
      if (to || br !== eb) begin n_fail++; $display("FAIL rand_bresp[%0d]: got %b expected %b", it, br, eb); end
      axi_read(a, len, 3'b101, bu, 2, to);
      n_tests++;
      if (to || got_d.size() != int'(len) + 1 || stab_err != 0) begin
        n_fail++; $display("FAIL rand_count[%0d]: got %0d stall_changes=%0d expected %0d", it, got_d.size(), stab_err, int'(len) + 1);
      end
      for (int k = 0; k < got_d.size() && k <= int'(len); k++) begin
        n_tests++;
        if (got_d[k] !== exp_rd(a, 3'b101, bu, k) || got_r[k] !== exp_rr(a, 3'b101, bu, k) || got_l[k] !== (k == int'(len))) begin
          n_fail++; $display("FAIL rand_beat[%0d.%0d]: got d=%h r=%b l=%b expected d=%h r=%b",
            it, k, got_d[k], got_r[k], got_l[k], exp_rd(a, 3'b101, bu, k), exp_rr(a, 3'b101, bu, k));
        end
      end
    end
  endtask

  task automatic test_reset_mid_read;
    int n;
    bit to;
    @(negedge clk);
    araddr = BASE; arlen = 4'd15; arsize = 3'b101; arburst = 2'b01; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 100) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({rvalid, rlast, rresp, rdata, arready, awready} !== '0) begin
      n_fail++; $display("FAIL reset_mid_read: got rvalid=%b rlast=%b rdata=%h expected 0", rvalid, rlast, rdata);
    end
    rready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    axi_read(BASE + 33'(3 * 32), 4'd7, 3'b101, 2'b01, 0, to);
    n_tests++;
    if (to || lat !== 2 || got_d.size() != 8) begin
      n_fail++; $display("FAIL after_reset_read: got lat=%0d n=%0d expected lat=2 n=8", lat, got_d.size());
    end
    for (int k = 0; k < got_d.size() && k < 8; k++) begin
      n_tests++;
      if (got_d[k] !== exp_rd(BASE + 33'(3 * 32), 3'b101, 2'b01, k)) begin
        n_fail++; $display("FAIL buffer_intact[%0d]: got %h expected %h", k, got_d[k], exp_rd(BASE + 33'(3 * 32), 3'b101, 2'b01, k));
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_basic();
    test_strobe();
    test_rready_toggle();
    test_boundary();
    test_illegal();
    test_random();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
